// File: rtl/vluint7_pkg.sv
// Shared definitions for the vluint7 byte-stream encoder.
// Groups are 7 payload bits, and the continuation flag is bit 7.
package vluint7_pkg;

    localparam int VLU_PAYLOAD_BITS = 7;
    localparam int VLU_CONT_BIT     = 7;

    function automatic int vlu_max_bytes(input int width);
        return (width + VLU_PAYLOAD_BITS - 1) / VLU_PAYLOAD_BITS;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_EMIT,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/vluint7_ser.sv
// Loadable shift register that emits one vluint7 byte at a time.
// The least significant 7-bit group is emitted first.
module vluint7_ser
    import vluint7_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [INSTR_WIDTH-1:0] i_data,
    input  logic                   i_shift,
    output logic [7:0]             o_byte,
    output logic                   o_last,
    output logic                   o_word_zero
);

    logic [INSTR_WIDTH-1:0] r_sr;
    logic                   r_zero;
    logic [INSTR_WIDTH-1:0] w_rest;
    logic                   w_cont;

    // The continuation flag looks at what is left once this group is gone.
    assign w_rest      = r_sr >> VLU_PAYLOAD_BITS;
    assign w_cont      = |w_rest;
    assign o_byte      = {w_cont, r_sr[VLU_PAYLOAD_BITS-1:0]};
    assign o_last      = ~w_cont;
    assign o_word_zero = r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr   <= '0;
            r_zero <= 1'b0;
        end else if (i_load) begin
            r_sr   <= i_data;
            r_zero <= (i_data == '0);
        end else if (i_shift) begin
            r_sr   <= w_rest;
        end
    end

endmodule

// File: rtl/encoder.sv
// Drains instruction words from a FIFO and writes them to memory as vluint7 bytes.
// Writing stops after the pair of zero words that marks the end of the program.
module encoder
    import vluint7_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      do_it,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    output logic [MEM_ADDR_WIDTH-1:0] addr_out,
    output logic                      busy,
    output logic                      done,
    input  logic                      fifo_empty,
    output logic                      fifo_rd,
    input  logic [INSTR_WIDTH-1:0]    fifo_data,
    output logic                      mem_wr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_wdata,
    input  logic                      mem_ready
);

    enc_state_t                r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_addr_out;
    logic                      r_last_zero;

    logic       w_emit;
    logic       w_load;
    logic       w_accept;
    logic [7:0] w_byte;
    logic       w_last;
    logic       w_word_zero;

    assign w_emit   = (r_state == ST_EMIT);
    assign w_load   = (r_state == ST_LOAD);
    assign w_accept = w_emit & mem_ready;

    vluint7_ser #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_data     (fifo_data),
        .i_shift    (w_accept),
        .o_byte     (w_byte),
        .o_last     (w_last),
        .o_word_zero(w_word_zero)
    );

    // FETCH leaves after one read, so the strobe can never repeat back to back.
    assign fifo_rd   = (r_state == ST_FETCH) & ~fifo_empty;
    assign mem_wr    = w_emit;
    assign mem_addr  = w_emit ? r_addr_out : '0;
    assign mem_wdata = w_emit ? w_byte : '0;
    assign addr_out  = r_addr_out;
    assign busy      = (r_state == ST_FETCH) | w_load | w_emit;
    assign done      = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr_out  <= '0;
            r_last_zero <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (do_it) begin
                        r_addr_out  <= addr;
                        r_last_zero <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (mem_ready) begin
                        r_addr_out <= r_addr_out + MEM_ADDR_WIDTH'(1);
                        if (w_last) begin
                            if (w_word_zero && r_last_zero) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_last_zero <= w_word_zero;
                                r_state     <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/encoder.md
# encoder

Write-side counterpart of the instruction decoder. The block drains instruction words from a synchronous FIFO, serialises each word as a vluint7 byte sequence, and writes the bytes to consecutive memory addresses starting at a given base. It stops after writing the two-zero-instruction terminator that the decoder uses to detect end of program, then reports the next free address.

## Interface
- `INSTR_WIDTH`, default 32: instruction word width.
- `MEM_ADDR_WIDTH`, default 16: byte address width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `do_it`  in  1  start pulse; sampled only in IDLE or DONE.
- `addr`  in  MEM_ADDR_WIDTH  base address, captured with `do_it`.
- `addr_out`  out  MEM_ADDR_WIDTH  next byte address to be written; final value = base + total bytes written.
- `busy`  out  1  high from accepted `do_it` until `done`.
- `done`  out  1  terminator written; held until next `do_it` or reset.
- `fifo_empty`  in  1  source FIFO empty.
- `fifo_rd`  out  1  single-cycle read strobe.
- `fifo_data`  in  INSTR_WIDTH  read data, valid the cycle after `fifo_rd`.
- `mem_wr`  out  1  byte write request.
- `mem_addr`  out  MEM_ADDR_WIDTH  write address.
- `mem_wdata`  out  8  write byte.
- `mem_ready`  in  1  memory accepts the write in the current cycle.

## Operation
- Encoding, vluint7 little-endian: each byte is {cont, payload[6:0]}, least significant 7-bit group first. `cont` = 1 iff any non-zero bits remain after this group. A zero word encodes as a single byte 0x00. The maximum length is ceil(INSTR_WIDTH/7) bytes, which is 5 at width 32.
- FSM states:
  - IDLE: outputs quiet. `do_it` → capture `addr` into `addr_out`, clear `last_zero`, go to FETCH.
  - FETCH: if `!fifo_empty`, pulse `fifo_rd` for one cycle and go to LOAD. Otherwise stay.
  - LOAD: capture `fifo_data` into the shift register and go to EMIT.
  - EMIT: drive `mem_wr`=1, `mem_addr`=`addr_out`, `mem_wdata`=current byte.
    - On a cycle with `mem_ready`: increment `addr_out` and shift right by 7.
    - After the last byte: if the word is 0 and `last_zero` is set, go to DONE. Otherwise set `last_zero` = (word==0) and go to FETCH.
  - DONE: `done`=1, `busy`=0. `do_it` → restart as from IDLE and clear `done`.
- `do_it` in FETCH, LOAD or EMIT is ignored.
- `addr_out` and `mem_addr` wrap modulo 2^MEM_ADDR_WIDTH silently.
- Width rule: shift register is INSTR_WIDTH bits, zero-filled from the top. `cont` is computed on the post-shift value.

## Timing
- Reset values: `fifo_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `addr_out`=0, `busy`=0, `done`=0. FSM goes to IDLE and `last_zero` clears.
- Reset mid-operation aborts immediately. The byte in flight may or may not have been accepted; no recovery is attempted.
- Write handshake:
  - `mem_addr` and `mem_wdata` stay stable while `mem_wr`=1 and `mem_ready`=0.
  - A byte transfers on a rising edge where `mem_wr` and `mem_ready` are both 1.
  - Back-to-back bytes are written at 1 byte/cycle.
- Latency: `do_it` at cycle 0 with a non-empty FIFO gives `fifo_rd` at cycle 1, LOAD at cycle 2, first `mem_wr` at cycle 3. Each word costs 2 cycles of fetch overhead plus its byte count, with `mem_ready` held high.
- `fifo_rd` is never asserted while `fifo_empty`=1 and is never asserted two cycles in a row.
- `done` rises the cycle after the terminator byte is accepted.

## Structure
- Shared package `vluint7_pkg` holds:
  - `VLU_PAYLOAD_BITS`=7 and `VLU_CONT_BIT`=7.
  - A function returning the max byte count for a given width.
  - The FSM state enum.
- Sub-module `vluint7_ser`: loadable shift register plus byte/cont generation with a `last` flag. It is the inverse of the decoder's `vluint7` reader. The top level holds the FSM, addressing and FIFO handshake.

## Test plan
- Base 0x0100, FIFO {0x0000012C, 0, 0}, `mem_ready`=1 → bytes AC 02 00 00 at 0x0100–0x0103; `done`=1 and `addr_out`=0x0104.
- FIFO {0xFFFFFFFF, 0x7F, 0x80, 0, 0} → FF FF FF FF 0F 7F 80 01 00 00; `addr_out` = base+10.
- FIFO {0, 5, 0, 0} → 00 05 00 00. A single zero does not terminate; `done` rises only after the second 00 of the consecutive pair.
- `mem_ready` toggled randomly and FIFO empty for 7 cycles between words → no `fifo_rd` while empty; address and data held stable while stalled; byte stream identical to the 0x12C case.
- Base 0xFFFE with word 300 and terminator → writes at FFFE, FFFF, 0000, 0001; `addr_out`=0x0002.
- Reset asserted during EMIT of a 5-byte word → all outputs 0 asynchronously. A later `do_it` with base 0x0200 encodes cleanly from 0x0200. A `do_it` pulse mid-EMIT is ignored.
